// File: rtl/fifo_burst_scheduler.sv
// fifo_burst_scheduler
//   Shares one write FIFO between two host requesters (round-robin) and
//   drains it toward the SDRAM command engine as fixed-length write bursts.
//   The FIFO only exposes empty/full, so the block tracks occupancy itself.
//
//   Optional feature, macro FLUSH_TIMEOUT_EN: when fewer than BURST_LEN words
//   sit idle for TIMEOUT cycles, a partial burst of the residual words is
//   issued. Without the macro only full BURST_LEN bursts are ever issued.
//
// Ports
//   clk, rst                 clock, async active-low reset
//   req{0,1}_valid/data      requester words in
//   req{0,1}_ready           word accepted this cycle (at most one high)
//   fifo_push/fifo_data_in   FIFO write side
//   fifo_pull/fifo_data_out  FIFO read side (data registered one cycle after pull)
//   fifo_full/fifo_empty     FIFO flags
//   burst_req/burst_ack      burst handshake with the SDRAM engine
//   burst_len                words in the requested burst
//   wr_valid/wr_data/wr_last burst data stream, no backpressure
module fifo_burst_scheduler #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  input  logic [DATA_W-1:0]          req0_data,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [DATA_W-1:0]          req1_data,
  output logic                       req1_ready,
  output logic                       fifo_push,
  output logic [DATA_W-1:0]          fifo_data_in,
  output logic                       fifo_pull,
  input  logic [DATA_W-1:0]          fifo_data_out,
  input  logic                       fifo_full,
  input  logic                       fifo_empty,
  output logic                       burst_req,
  input  logic                       burst_ack,
  output logic [$clog2(DEPTH+1)-1:0] burst_len,
  output logic                       wr_valid,
  output logic [DATA_W-1:0]          wr_data,
  output logic                       wr_last
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] BL = CW'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, REQ, PULL, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] occ, cnt, cnt_nxt, len_nxt, launch_len;
  logic          prio, launch, burst_req_nxt, pull_nxt, last_nxt;

  // Round-robin grant: prio names the preferred requester.
  assign req0_ready   = !fifo_full && req0_valid && (!prio || !req1_valid);
  assign req1_ready   = !fifo_full && req1_valid && ( prio || !req0_valid);
  assign fifo_push    = req0_ready | req1_ready;
  assign fifo_data_in = req1_ready ? req1_data : req0_data;

  // FIFO read data already lands one cycle after pull, aligned with wr_valid;
  // gating keeps the port at zero outside a data beat and during reset.
  assign wr_data = wr_valid ? fifo_data_out : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio <= 1'b0;
      occ  <= '0;
    end else begin
      if (req0_ready)      prio <= 1'b1;
      else if (req1_ready) prio <= 1'b0;
      if (fifo_push && !fifo_pull)      occ <= occ + CW'(1);
      else if (!fifo_push && fifo_pull) occ <= occ - CW'(1);
    end
  end

`ifdef FLUSH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT-1);

  logic [TW-1:0] idle_cnt;
  logic          partial;

  // Residual words waiting with no new traffic; any push restarts the wait.
  assign partial = (state == IDLE) && (occ != '0) && (occ < BL) && !fifo_push;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   idle_cnt <= '0;
    else if (partial && !launch) idle_cnt <= idle_cnt + TW'(1);
    else                        idle_cnt <= '0;
  end

  always_comb begin
    launch     = (occ >= BL);
    launch_len = BL;
    if (partial && idle_cnt == TO_LAST) begin
      launch     = 1'b1;
      launch_len = occ;
    end
  end
`else
  assign launch     = (occ >= BL);
  assign launch_len = BL;
`endif

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    burst_req_nxt = burst_req;
    len_nxt       = burst_len;
    pull_nxt      = 1'b0;
    last_nxt      = 1'b0;
    case (state)
      IDLE: if (launch) begin
        burst_req_nxt = 1'b1;
        len_nxt       = launch_len;
        state_nxt     = REQ;
      end
      REQ: if (burst_ack) begin
        burst_req_nxt = 1'b0;
        cnt_nxt       = burst_len;
        pull_nxt      = 1'b1;
        state_nxt     = PULL;
      end
      // cnt counts pulls still to issue including the one on the wire now.
      PULL: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          last_nxt  = 1'b1;
          state_nxt = DRAIN;
        end else begin
          pull_nxt = 1'b1;
        end
      end
      DRAIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      burst_req <= 1'b0;
      burst_len <= '0;
      fifo_pull <= 1'b0;
      wr_valid  <= 1'b0;
      wr_last   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      burst_req <= burst_req_nxt;
      burst_len <= len_nxt;
      fifo_pull <= pull_nxt;
      wr_valid  <= fifo_pull;
      wr_last   <= last_nxt;
    end
  end

`ifndef SYNTHESIS
  localparam bit CFG_OK = (BURST_LEN >= 1) && (BURST_LEN <= DEPTH) && (TIMEOUT >= 1);
  // A pull against an empty FIFO means occ drifted from the real FIFO.
  a_no_pull_empty: assert property (@(posedge clk) disable iff (!rst) !(fifo_pull && fifo_empty));
  a_cfg_ok:        assert property (@(posedge clk) CFG_OK);
`endif

endmodule

// File: tb/tb_fifo_burst_scheduler.sv
module tb_fifo_burst_scheduler;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int BL     = 4;
  localparam int TO     = 16;
  localparam int LW     = $clog2(DEPTH+1);

  logic              clk = 1'b0, rst = 1'b0;
  logic              req0_valid = 1'b0, req1_valid = 1'b0, burst_ack = 1'b0;
  logic [DATA_W-1:0] req0_data = '0, req1_data = '0;
  logic              req0_ready, req1_ready, fifo_push, fifo_pull, fifo_full, fifo_empty;
  logic              burst_req, wr_valid, wr_last;
  logic [DATA_W-1:0] fifo_data_in, fifo_data_out, wr_data;
  logic [LW-1:0]     burst_len;

  fifo_burst_scheduler #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .fifo_push(fifo_push), .fifo_data_in(fifo_data_in),
    .fifo_pull(fifo_pull), .fifo_data_out(fifo_data_out),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .burst_req(burst_req), .burst_ack(burst_ack), .burst_len(burst_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last)
  );

  always #5 clk = ~clk;

  // Attached FIFO: registered read data, flags from its own count.
  logic [DATA_W-1:0] mem [DEPTH];
  int f_cnt, f_wp, f_rp;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_cnt <= 0; f_wp <= 0; f_rp <= 0; fifo_data_out <= '0;
    end else begin
      if (fifo_push && f_cnt < DEPTH) begin
        mem[f_wp] <= fifo_data_in;
        f_wp <= (f_wp + 1) % DEPTH;
      end
      if (fifo_pull && f_cnt > 0) begin
        fifo_data_out <= mem[f_rp];
        f_rp <= (f_rp + 1) % DEPTH;
      end
      f_cnt <= f_cnt + int'(fifo_push && f_cnt < DEPTH) - int'(fifo_pull && f_cnt > 0);
    end
  end
  assign fifo_full  = (f_cnt == DEPTH);
  assign fifo_empty = (f_cnt == 0);

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: words in FIFO order, who is preferred, and the
  // outstanding pull / write beats of the burst in flight.
  logic [DATA_W-1:0] m_fifo[$];
  logic [DATA_W-1:0] push_log[$];
  bit                m_prio, m_rd_vld, m_rd_last;
  logic [DATA_W-1:0] m_rd;
  int                m_pull_rem, m_burst_words, stuck, ack_dly;
  bit                p_req, p_ack, ack_block, s_e0, s_e1, s_req;
  logic [LW-1:0]     p_len;

  task automatic model_reset();
    m_fifo.delete();
    m_prio = 0; m_rd_vld = 0; m_rd_last = 0;
    m_pull_rem = 0; m_burst_words = 0; stuck = 0;
    p_req = 0; p_ack = 0; ack_dly = 0;
  endtask

  task automatic step();
    bit full, e0, e1, pulled, ack;
    logic [DATA_W-1:0] d0, d1;
    int exp_len;
    @(negedge clk);
    full = (m_fifo.size() == DEPTH);
    e0 = !full && req0_valid && (!m_prio || !req1_valid);
    e1 = !full && req1_valid && ( m_prio || !req0_valid);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("fifo_push", fifo_push, e0 || e1);
    if (e0 || e1) chk("fifo_data_in", fifo_data_in, e0 ? req0_data : req1_data);
    chk("fifo_pull", fifo_pull, m_pull_rem > 0);
    if (fifo_pull) chk("pull_nonempty", m_fifo.size() > 0, 1);
    chk("wr_valid", wr_valid, m_rd_vld);
    if (m_rd_vld) begin
      chk("wr_data", wr_data, m_rd);
      chk("wr_last", wr_last, m_rd_last);
    end else begin
      chk("wr_last_idle", wr_last, 1'b0);
    end
    if (burst_req && !p_req) begin
      exp_len = BL;
`ifdef FLUSH_TIMEOUT_EN
      if (m_fifo.size() < BL) exp_len = m_fifo.size();
`endif
      chk("burst_len", burst_len, exp_len);
      chk("launch_occ", m_fifo.size() >= exp_len, 1);
    end
    if (p_req && !p_ack) begin
      chk("req_hold", burst_req, 1);
      chk("len_hold", burst_len, p_len);
    end
    if (p_req && p_ack) chk("req_drop", burst_req, 0);
    if (m_pull_rem > 0 || m_rd_vld) chk("req_busy", burst_req, 0);
    if (!burst_req && m_pull_rem == 0 && !m_rd_vld && m_fifo.size() >= BL) stuck++;
    else stuck = 0;
    chk("launch_wait", stuck <= 2, 1);

    ack = burst_req && burst_ack;
    p_req = burst_req; p_ack = burst_ack; p_len = burst_len;
    pulled = fifo_pull; d0 = req0_data; d1 = req1_data;
    s_e0 = e0; s_e1 = e1; s_req = burst_req;
    @(posedge clk);
    m_rd_vld = 0;
    if (pulled && m_fifo.size() > 0) begin
      m_rd = m_fifo.pop_front();
      m_rd_vld = 1;
      m_burst_words--;
      m_rd_last = (m_burst_words == 0);
    end
    if (e0) begin m_fifo.push_back(d0); push_log.push_back(d0); m_prio = 1; end
    else if (e1) begin m_fifo.push_back(d1); push_log.push_back(d1); m_prio = 0; end
    if (m_pull_rem > 0) m_pull_rem--;
    if (ack) begin m_pull_rem = int'(p_len); m_burst_words = int'(p_len); end
    #1;
  endtask

  // Drive one cycle of requester inputs plus an SDRAM engine that acks
  // after a random 0..3 cycle delay.
  task automatic cyc(input bit v0, input logic [DATA_W-1:0] d0,
                     input bit v1, input logic [DATA_W-1:0] d1);
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    if (burst_req && !ack_block) begin
      if (ack_dly == 0) burst_ack = 1'b1;
      else begin ack_dly--; burst_ack = 1'b0; end
    end else begin
      burst_ack = 1'b0;
      ack_dly = $urandom_range(0, 3);
    end
    step();
  endtask

  task automatic chk_rst_outs(input string tag);
    chk({tag, "_burst_req"}, burst_req, 0);
    chk({tag, "_burst_len"}, burst_len, 0);
    chk({tag, "_fifo_pull"}, fifo_pull, 0);
    chk({tag, "_wr_valid"}, wr_valid, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_wr_last"}, wr_last, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req0_valid = 0; req1_valid = 0; burst_ack = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    int n0, n1, lat, rate;
    bit seen;
    logic [DATA_W-1:0] exp_c [4];
    model_reset();
    ack_block = 0;
    repeat (2) @(posedge clk);
    #1 chk_rst_outs("reset");
    rst = 1'b1;

    // Contention with the engine stalled: alternate grants, then fill up.
    ack_block = 1; n0 = 0; n1 = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(1, 16'hA000 + 16'(n0), 1, 16'hB000 + 16'(n1));
      if (s_e0) n0++;
      if (s_e1) n1++;
    end
    exp_c = '{16'hA000, 16'hB000, 16'hA001, 16'hB001};
    for (int i = 0; i < 4; i++) chk("contention_order", push_log[i], exp_c[i]);
    chk("full_pushes", push_log.size(), DEPTH);
    chk("full_req", burst_req, 1);
    chk("full_len", burst_len, BL);

    // Release the engine; pushes resume while the burst drains.
    ack_block = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1, 16'hA000 + 16'(n0), 1, 16'hB000 + 16'(n1));
      if (s_e0) n0++;
      if (s_e1) n1++;
    end
    for (int i = 0; i < 20; i++) cyc(0, '0, 0, '0);

    // Single requester streaming: pushes overlap pulls.
    for (int i = 0; i < 40; i++) cyc(1, DATA_W'($urandom), 0, '0);

    // Reset in the second pull cycle of a burst.
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      cyc(1, DATA_W'($urandom), 0, '0);
      if (m_rd_vld && m_pull_rem == BL - 1) seen = 1;
    end
    chk("reach_pull2", seen, 1);
    #2 rst = 1'b0;
    #1 chk_rst_outs("midburst");
    do_reset();
    for (int i = 0; i < 12; i++) cyc(1, DATA_W'($urandom), 0, '0);
    for (int i = 0; i < 10; i++) cyc(0, '0, 0, '0);

    // Random traffic, alternating light and heavy load.
    for (int i = 0; i < 1500; i++) begin
      rate = ((i / 300) % 2) ? 60 : 25;
      cyc($urandom_range(0, 99) < rate, DATA_W'($urandom),
          $urandom_range(0, 99) < rate, DATA_W'($urandom));
    end

    // Residual of 3 words, then silence.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, DATA_W'($urandom), 0, '0);
    seen = 0; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(0, '0, 0, '0);
      if (s_req && !seen) begin seen = 1; lat = i - 1; end
    end
`ifdef FLUSH_TIMEOUT_EN
    chk("flush_seen", seen, 1);
    chk("flush_latency", lat, TO);
`else
    chk("no_flush", seen, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
